// File: rtl/apb_slave_ws.sv
// APB4-style memory slave with programmable read/write wait states and registered read data.
// Optional macro APB_SLAVE_PSTRB_EN enables per-byte write strobes.
module apb_slave_ws #(
    parameter int unsigned MEM_DEPTH   = 16,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BASEADDRESS = 0,
    parameter int unsigned WR_WAIT     = 0,
    parameter int unsigned RD_WAIT     = 1
) (
    input  logic                    I_PCLK,
    input  logic                    I_PRESET,
    input  logic [ADDR_WIDTH-1:0]   I_PADDR,
    input  logic                    I_PSEL,
    input  logic                    I_PENABLE,
    input  logic                    I_PWRITE,
    input  logic [DATA_WIDTH-1:0]   I_PWDATA,
    input  logic [DATA_WIDTH/8-1:0] I_PSTRB,
    output logic                    O_PREADY,
    output logic [DATA_WIDTH-1:0]   O_PRDATA,
    output logic                    O_PSLVERR
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned LSB    = $clog2(NBYTES);
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);

    localparam logic [63:0] BASE64 = 64'(BASEADDRESS);
    localparam logic [63:0] END64  = BASE64 + 64'(MEM_DEPTH) * 64'(NBYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << LSB) - 64'd1);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  err_q, err_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                  ready;
    logic                  mem_we;
    logic [63:0]           paddr64;
    logic                  setup_err;
    logic [IDX_W-1:0]      setup_idx;

    assign paddr64   = 64'(I_PADDR);
    assign setup_err = (paddr64 < BASE64) || (paddr64 >= END64) || (|(I_PADDR & ALIGN_MASK));
    assign setup_idx = IDX_W'((I_PADDR - ADDR_WIDTH'(BASEADDRESS)) >> LSB);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        err_d    = err_q;
        write_d  = write_q;
        prdata_d = prdata_q;
        mem_we   = 1'b0;
        ready    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // PENABLE high while idle is not a valid setup phase and is ignored
                if (I_PSEL && !I_PENABLE) begin
                    state_d = StAccess;
                    idx_d   = setup_idx;
                    err_d   = setup_err;
                    write_d = I_PWRITE;
                    cnt_d   = I_PWRITE ? 4'(WR_WAIT) : 4'(RD_WAIT);
                    if (!I_PWRITE) begin
                        prdata_d = setup_err ? '0 : mem_q[setup_idx];
                    end
                end
            end
            StAccess: begin
                ready = I_PSEL && I_PENABLE && (cnt_q == 4'd0);
                if (!I_PSEL) begin
                    state_d = StIdle;
                end else if (ready) begin
                    state_d = StIdle;
                    mem_we  = write_q && !err_q;
                end else if (I_PENABLE) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge I_PCLK) begin
        if (I_PRESET) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            write_q  <= write_d;
            prdata_q <= prdata_d;
        end
    end

    always_ff @(posedge I_PCLK) begin
        if (I_PRESET) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
`ifdef APB_SLAVE_PSTRB_EN
            for (int b = 0; b < int'(NBYTES); b++) begin
                if (I_PSTRB[b]) begin
                    mem_q[idx_q][b*8 +: 8] <= I_PWDATA[b*8 +: 8];
                end
            end
`else
            mem_q[idx_q] <= I_PWDATA;
`endif
        end
    end

`ifndef APB_SLAVE_PSTRB_EN
    logic unused_strb;
    assign unused_strb = ^I_PSTRB;
`endif

    assign O_PREADY  = ready;
    assign O_PSLVERR = ready && err_q;
    assign O_PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slave_ws.sv
// Directed bench for apb_slave_ws: instance 0 uses WR_WAIT=0/RD_WAIT=1, instance 1 uses
// WR_WAIT=2/RD_WAIT=0; both map 16 words at byte address 0x100.
module tb_apb_slave_ws;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] paddr;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [1:0]  psel;
    logic [1:0]  pready;
    logic [1:0]  pslverr;
    logic [31:0] prdata0;
    logic [31:0] prdata1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_slave_ws #(
        .MEM_DEPTH(16), .ADDR_WIDTH(16), .DATA_WIDTH(32), .BASEADDRESS(32'h100),
        .WR_WAIT(0), .RD_WAIT(1)
    ) u_dut0 (
        .I_PCLK(clk), .I_PRESET(rst), .I_PADDR(paddr), .I_PSEL(psel[0]),
        .I_PENABLE(penable), .I_PWRITE(pwrite), .I_PWDATA(pwdata), .I_PSTRB(pstrb),
        .O_PREADY(pready[0]), .O_PRDATA(prdata0), .O_PSLVERR(pslverr[0])
    );

    apb_slave_ws #(
        .MEM_DEPTH(16), .ADDR_WIDTH(16), .DATA_WIDTH(32), .BASEADDRESS(32'h100),
        .WR_WAIT(2), .RD_WAIT(0)
    ) u_dut1 (
        .I_PCLK(clk), .I_PRESET(rst), .I_PADDR(paddr), .I_PSEL(psel[1]),
        .I_PENABLE(penable), .I_PWRITE(pwrite), .I_PWDATA(pwdata), .I_PSTRB(pstrb),
        .O_PREADY(pready[1]), .O_PRDATA(prdata1), .O_PSLVERR(pslverr[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Setup cycle, then access cycles until PREADY (max 20); cyc=0 means it never completed.
    task automatic xfer(input int u, input logic wr, input logic [15:0] a,
                        input logic [31:0] wd, input logic [3:0] sb,
                        output logic [31:0] rd, output logic er, output int cyc);
        cyc = 0;
        rd  = '0;
        er  = 1'b0;
        @(posedge clk); #1;
        psel    = 2'b00;
        psel[u] = 1'b1;
        penable = 1'b0;
        paddr   = a;
        pwrite  = wr;
        pwdata  = wd;
        pstrb   = sb;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            penable = 1'b1;
            #1;
            if (pready[u]) begin
                cyc = n;
                rd  = (u == 0) ? prdata0 : prdata1;
                er  = pslverr[u];
                break;
            end
        end
    endtask

    task automatic do_write(input int u, input string tag, input logic [15:0] a,
                            input logic [31:0] wd, input logic [3:0] sb,
                            input logic exp_err, input int exp_cyc);
        logic [31:0] rd;
        logic        er;
        int          cyc;
        xfer(u, 1'b1, a, wd, sb, rd, er, cyc);
        check({tag, "_lat"}, cyc, exp_cyc);
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    task automatic do_read(input int u, input string tag, input logic [15:0] a,
                           input logic [31:0] exp_data, input logic exp_err, input int exp_cyc);
        logic [31:0] rd;
        logic        er;
        int          cyc;
        xfer(u, 1'b0, a, 32'h0, 4'h0, rd, er, cyc);
        check({tag, "_lat"}, cyc, exp_cyc);
        check({tag, "_data"}, rd, exp_data);
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    task automatic idle();
        @(posedge clk); #1;
        psel    = 2'b00;
        penable = 1'b0;
    endtask

    initial begin
        logic [31:0] strb_exp;
        rst     = 1'b1;
        psel    = 2'b00;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_pready", {31'd0, pready[0]}, 32'd0);
        check("rst_prdata", prdata0, 32'h0);
        check("rst_pslverr", {31'd0, pslverr[0]}, 32'd0);

        // Read after reset: one wait state
        do_read(0, "rd_base", 16'h100, 32'h0, 1'b0, 2);

        // Zero-wait write, then read-back
        do_write(0, "wr_dead", 16'h108, 32'hDEADBEEF, 4'hF, 1'b0, 1);
        do_read(0, "rd_dead", 16'h108, 32'hDEADBEEF, 1'b0, 2);

        // Error writes; ENDADDRESS index would alias word 0 if the error were ignored
        do_write(0, "wr_end", 16'h140, 32'h11111111, 4'hF, 1'b1, 1);
        check("prdata_hold", prdata0, 32'hDEADBEEF);
        do_write(0, "wr_misal", 16'h102, 32'h22222222, 4'hF, 1'b1, 1);
        do_write(0, "wr_below", 16'h0FC, 32'h33333333, 4'hF, 1'b1, 1);
        do_read(0, "rd_w0", 16'h100, 32'h0, 1'b0, 2);
        do_read(0, "rd_dead2", 16'h108, 32'hDEADBEEF, 1'b0, 2);
        do_read(0, "rd_err", 16'h142, 32'h0, 1'b1, 2);

        // Back-to-back writes to every word, then back-to-back reads
        for (int i = 0; i < 16; i++) begin
            do_write(0, $sformatf("b2b_wr%0d", i), 16'(16'h100 + i * 4), 32'(i), 4'hF, 1'b0, 1);
        end
        for (int i = 0; i < 16; i++) begin
            do_read(0, $sformatf("b2b_rd%0d", i), 16'(16'h100 + i * 4), 32'(i), 1'b0, 2);
        end
        idle();

        // Instance 1: two write wait states, zero read wait states
        do_write(1, "w1_wr", 16'h104, 32'hA5A5A5A5, 4'hF, 1'b0, 3);
        do_read(1, "w1_rd", 16'h104, 32'hA5A5A5A5, 1'b0, 1);
        idle();

        // Abort: drop PSEL during a write wait cycle
        @(posedge clk); #1;
        psel    = 2'b10;
        penable = 1'b0;
        paddr   = 16'h10C;
        pwrite  = 1'b1;
        pwdata  = 32'h12345678;
        pstrb   = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        check("abort_wait_rdy", {31'd0, pready[1]}, 32'd0);
        @(posedge clk); #1;
        psel = 2'b00;
        #1;
        check("abort_rdy", {31'd0, pready[1]}, 32'd0);
        check("abort_err", {31'd0, pslverr[1]}, 32'd0);
        @(posedge clk); #1;
        penable = 1'b0;
        do_read(1, "abort_rd", 16'h10C, 32'h0, 1'b0, 1);
        idle();

        // Reset asserted in the wait cycle of a read of word 5
        @(posedge clk); #1;
        psel    = 2'b01;
        penable = 1'b0;
        paddr   = 16'h114;
        pwrite  = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        check("rstmid_wait_rdy", {31'd0, pready[0]}, 32'd0);
        check("rstmid_prdata", prdata0, 32'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_rdy", {31'd0, pready[0]}, 32'd0);
        check("rstmid_err", {31'd0, pslverr[0]}, 32'd0);
        check("rstmid_prdata0", prdata0, 32'h0);
        rst     = 1'b0;
        psel    = 2'b00;
        penable = 1'b0;
        do_read(0, "rstmid_rd5", 16'h114, 32'h0, 1'b0, 2);
        do_read(0, "rstmid_rd2", 16'h108, 32'h0, 1'b0, 2);

        // Byte strobes
`ifdef APB_SLAVE_PSTRB_EN
        strb_exp = 32'hFFAAFFFF;
`else
        strb_exp = 32'h00AA0000;
`endif
        do_write(0, "strb_ff", 16'h118, 32'hFFFFFFFF, 4'hF, 1'b0, 1);
        do_write(0, "strb_lane", 16'h118, 32'h00AA0000, 4'b0100, 1'b0, 1);
        do_read(0, "strb_rd", 16'h118, strb_exp, 1'b0, 2);
        idle();
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
